// File: rtl/mvf_block_rasterizer.sv
// rtl/mvf_block_rasterizer.sv - rasterises block motion-vector descriptors into an MV/priority field RAM
module mvf_block_rasterizer #(
  parameter int MV_W    = 9,
  parameter int NCH     = 2,
  parameter int PRI_W   = 6,
  parameter int COORD_W = 8,
  parameter int FIELD_W = 256,
  parameter int FIELD_H = 256,
  parameter int ADDR_W  = 16
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mode,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [COORD_W-1:0]    blk_x,
  input  logic [COORD_W-1:0]    blk_y,
  input  logic [COORD_W-1:0]    blk_w,
  input  logic [COORD_W-1:0]    blk_h,
  input  logic [NCH*MV_W-1:0]   blk_mv,
  input  logic [PRI_W-1:0]      blk_pri,
  input  logic                  blk_last,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [NCH*MV_W-1:0]   ram_mv_out,
  output logic [PRI_W-1:0]      ram_pri_out,
  input  logic [PRI_W-1:0]      ram_pri_in,
  output logic                  busy,
  output logic                  blk_done,
  output logic                  field_done,
  output logic [ADDR_W-1:0]     wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_CHK, S_FIN} state_t;

  localparam logic [31:0] FW32 = 32'(FIELD_W);
  localparam logic [31:0] FH32 = 32'(FIELD_H);

  state_t               state, state_d;
  logic [COORD_W-1:0]   x_q, y_q, w_q, h_q, row, col, row_d, col_d;
  logic [NCH*MV_W-1:0]  mv_q;
  logic [PRI_W-1:0]     pri_q;
  logic                 last_q, mode_q;
  logic                 stale, stale_d;
  logic                 field_done_q;
  logic [ADDR_W-1:0]    wr_count_q;

  logic [COORD_W:0]     cx, cy;
  logic                 clipped, last_col, last_row;
  logic                 accept, adv, we, done;

  // Widened by one bit so a block hanging off the edge is clipped rather than wrapped
  assign cx       = {1'b0, x_q} + {1'b0, col};
  assign cy       = {1'b0, y_q} + {1'b0, row};
  assign clipped  = (32'(cx) >= FW32) || (32'(cy) >= FH32);
  assign last_col = (col == w_q - COORD_W'(1));
  assign last_row = (row == h_q - COORD_W'(1));

  always_comb begin
    state_d   = state;
    row_d     = row;
    col_d     = col;
    stale_d   = stale;
    blk_ready = 1'b0;
    accept    = 1'b0;
    adv       = 1'b0;
    we        = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        blk_ready = enable && !reset;
        if (blk_valid && blk_ready) begin
          accept  = 1'b1;
          row_d   = '0;
          col_d   = '0;
          stale_d = 1'b0;
          state_d = (blk_w == '0 || blk_h == '0) ? S_FIN : S_SCAN;
        end
      end
      S_SCAN: begin
        if (enable) begin
          if (clipped) begin
            adv = 1'b1;
          end else if (!mode_q) begin
            we  = 1'b1;
            adv = 1'b1;
          end else begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        // After a stall the read data may be stale: spend one cycle re-reading the held address
        if (!enable) begin
          stale_d = 1'b1;
        end else if (stale) begin
          stale_d = 1'b0;
        end else begin
          we  = (pri_q >= ram_pri_in);
          adv = 1'b1;
        end
      end
      S_FIN: begin
        if (enable) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      state_d = S_SCAN;
      if (last_col) begin
        col_d = '0;
        if (last_row) state_d = S_FIN;
        else          row_d   = row + COORD_W'(1);
      end else begin
        col_d = col + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state        <= S_IDLE;
      row          <= '0;
      col          <= '0;
      stale        <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      mv_q         <= '0;
      pri_q        <= '0;
      last_q       <= 1'b0;
      mode_q       <= 1'b0;
      field_done_q <= 1'b0;
      wr_count_q   <= '0;
    end else begin
      state <= state_d;
      row   <= row_d;
      col   <= col_d;
      stale <= stale_d;
      if (accept) begin
        x_q          <= blk_x;
        y_q          <= blk_y;
        w_q          <= blk_w;
        h_q          <= blk_h;
        mv_q         <= blk_mv;
        pri_q        <= blk_pri;
        last_q       <= blk_last;
        mode_q       <= mode;
        field_done_q <= 1'b0;
        if (field_done_q) wr_count_q <= '0;
      end
      if (done && last_q) field_done_q <= 1'b1;
      if (we) wr_count_q <= wr_count_q + ADDR_W'(1);
    end
  end

  assign busy        = (state != S_IDLE);
  assign blk_done    = done;
  assign ram_we      = we;
  assign field_done  = field_done_q;
  assign wr_count    = wr_count_q;
  assign ram_mv_out  = busy ? mv_q : '0;
  assign ram_pri_out = busy ? pri_q : '0;
  assign ram_addr    = (state == S_SCAN || state == S_CHK)
                       ? ADDR_W'(cy) * ADDR_W'(FIELD_W) + ADDR_W'(cx) : '0;

endmodule

// File: tb/tb_mvf_block_rasterizer.sv
// tb/tb_mvf_block_rasterizer.sv - self-checking bench for mvf_block_rasterizer
module tb_mvf_block_rasterizer;

  logic        CLK = 1'b0;
  logic        reset, enable, mode, blk_valid, blk_ready, blk_last;
  logic [7:0]  blk_x, blk_y, blk_w, blk_h;
  logic [17:0] blk_mv, ram_mv_out;
  logic [5:0]  blk_pri, ram_pri_out, ram_pri_in;
  logic [15:0] ram_addr, wr_count;
  logic        ram_we, busy, blk_done, field_done;

  mvf_block_rasterizer dut (
    .CLK(CLK), .reset(reset), .enable(enable), .mode(mode),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_x(blk_x), .blk_y(blk_y), .blk_w(blk_w), .blk_h(blk_h),
    .blk_mv(blk_mv), .blk_pri(blk_pri), .blk_last(blk_last),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_mv_out(ram_mv_out),
    .ram_pri_out(ram_pri_out), .ram_pri_in(ram_pri_in),
    .busy(busy), .blk_done(blk_done), .field_done(field_done), .wr_count(wr_count)
  );

  always #5 CLK = ~CLK;

  // External RAM seen by the DUT, plus write monitor
  bit [17:0] mem_mv  [65536];
  bit [5:0]  mem_pri [65536];
  int        we_cnt = 0;
  int        addr_q[$];

  always @(posedge CLK) begin
    ram_pri_in <= mem_pri[ram_addr];
    if (ram_we) begin
      mem_mv[ram_addr]  <= ram_mv_out;
      mem_pri[ram_addr] <= ram_pri_out;
      we_cnt = we_cnt + 1;
      addr_q.push_back(int'(ram_addr));
    end
  end

  // Reference field contents and bookkeeping
  bit [17:0] gm_mv  [65536];
  bit [5:0]  gm_pri [65536];
  int        exp_wrc   = 0;
  bit        prev_last = 0;
  int        n_checks  = 0;
  int        n_fail    = 0;

  task automatic check_eq(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Field-level semantics: each in-field entry is written in mode 0, or in mode 1
  // when the new priority is at least the stored one. Clipped entries cost one cycle.
  task automatic model_block(input int x, y, w, h, input bit md, input int pri,
                             input bit [17:0] mv, input bit last,
                             output int m_wr, output int m_cyc);
    m_wr = 0;
    m_cyc = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        int a;
        if (x + c >= 256 || y + r >= 256) begin
          m_cyc += 1;
          continue;
        end
        a = (y + r) * 256 + (x + c);
        m_cyc += md ? 2 : 1;
        if (!md || pri >= int'(gm_pri[a])) begin
          gm_mv[a]  = mv;
          gm_pri[a] = 6'(pri);
          m_wr++;
        end
      end
    if (prev_last) exp_wrc = 0;
    exp_wrc   = (exp_wrc + m_wr) % 65536;
    prev_last = last;
  endtask

  task automatic check_region(input string nm, input int x, y, w, h);
    int bad = 0, bad_a = -1;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (x + c < 256 && y + r < 256) begin
          int a = (y + r) * 256 + (x + c);
          if (mem_mv[a] != gm_mv[a] || mem_pri[a] != gm_pri[a]) begin
            bad++;
            if (bad_a < 0) bad_a = a;
          end
        end
    check_eq({nm, " ram_bad_entries(first addr ", $sformatf("%0d", bad_a), ")"}, bad, 0);
  endtask

  task automatic start_block(input int x, y, w, h, input bit md, input int pri,
                             input bit [17:0] mv, input bit last, input string nm);
    @(negedge CLK);
    blk_x = 8'(x); blk_y = 8'(y); blk_w = 8'(w); blk_h = 8'(h);
    mode = md; blk_pri = 6'(pri); blk_mv = mv; blk_last = last;
    blk_valid = 1'b1;
    #1;
    check_eq({nm, " blk_ready"}, blk_ready, 1);
    @(posedge CLK);
    #1;
    blk_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (!blk_done && n < 300) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (!blk_done) check_eq({nm, " blk_done_timeout"}, 0, 1);
  endtask

  task automatic post_checks(input string nm, input bit last);
    @(posedge CLK);
    #1;
    check_eq({nm, " blk_done_one_cycle"}, blk_done, 0);
    check_eq({nm, " busy_after"}, busy, 0);
    check_eq({nm, " field_done"}, field_done, last);
    check_eq({nm, " wr_count"}, wr_count, exp_wrc);
  endtask

  task automatic run_block(input int x, y, w, h, input bit md, input int pri,
                           input bit [17:0] mv, input bit last,
                           input int exp_cyc, input int exp_wr, input string nm);
    int m_wr, m_cyc, n, we0;
    model_block(x, y, w, h, md, pri, mv, last, m_wr, m_cyc);
    if (exp_cyc < 0) exp_cyc = m_cyc;
    if (exp_wr < 0)  exp_wr  = m_wr;
    addr_q.delete();
    we0 = we_cnt;
    start_block(x, y, w, h, md, pri, mv, last, nm);
    wait_done(nm, n);
    check_eq({nm, " cycles"}, n, exp_cyc);
    check_eq({nm, " writes"}, we_cnt - we0, exp_wr);
    post_checks(nm, last);
    check_region(nm, x, y, w, h);
  endtask

  typedef struct {
    int x, y, w, h;
    bit md;
    int pri;
    bit last;
    int cyc, wr;
    string nm;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n, we0, we_s, m_wr, m_cyc;
    reset = 1'b1; enable = 1'b1; mode = 1'b0; blk_valid = 1'b0; blk_last = 1'b0;
    blk_x = '0; blk_y = '0; blk_w = '0; blk_h = '0; blk_mv = '0; blk_pri = '0;

    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst blk_ready", blk_ready, 0);
    check_eq("rst ram_we", ram_we, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst blk_done", blk_done, 0);
    check_eq("rst field_done", field_done, 0);
    check_eq("rst ram_addr", ram_addr, 0);
    check_eq("rst wr_count", wr_count, 0);
    check_eq("rst ram_mv_out", ram_mv_out, 0);
    reset = 1'b0;

    vecs.push_back('{2,   1,   2, 2, 0, 3,  0, 4, 4, "v0 2x2 overwrite"});
    vecs.push_back('{50,  60,  1, 1, 0, 10, 0, 1, 1, "v1 preload pri10"});
    vecs.push_back('{50,  60,  1, 1, 1, 9,  0, 2, 0, "v2 merge pri9 loses"});
    vecs.push_back('{50,  60,  1, 1, 1, 10, 0, 2, 1, "v3 merge pri10 tie wins"});
    vecs.push_back('{254, 5,   4, 1, 0, 7,  0, 4, 2, "v4 right clip"});
    vecs.push_back('{20,  255, 2, 3, 1, 63, 0, 8, 2, "v5 bottom clip merge"});
    vecs.push_back('{0,   0,   0, 3, 0, 1,  1, 0, 0, "v6 empty last"});
    vecs.push_back('{3,   3,   1, 1, 0, 2,  0, 1, 1, "v7 new field"});
    vecs.push_back('{9,   9,   3, 0, 1, 2,  0, 0, 0, "v8 zero height"});

    for (int i = 0; i < vecs.size(); i++) begin
      run_block(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].md, vecs[i].pri,
                18'(32'h1000 + i * 32'h2345), vecs[i].last, vecs[i].cyc, vecs[i].wr, vecs[i].nm);
      if (i == 0) begin
        check_eq("v0 addr count", addr_q.size(), 4);
        if (addr_q.size() == 4) begin
          check_eq("v0 addr0", addr_q[0], 258);
          check_eq("v0 addr1", addr_q[1], 259);
          check_eq("v0 addr2", addr_q[2], 514);
          check_eq("v0 addr3", addr_q[3], 515);
        end
      end
    end

    // Stall in the merge-check cycle for three cycles, then resume
    run_block(10, 10, 2, 1, 0, 5, 18'h0aaaa, 0, 2, 2, "stall preload");
    model_block(10, 10, 2, 1, 1, 7, 18'h15555, 0, m_wr, m_cyc);
    check_eq("stall model writes", m_wr, 2);
    we0 = we_cnt;
    start_block(10, 10, 2, 1, 1, 7, 18'h15555, 0, "stall");
    @(posedge CLK);
    #1;
    enable = 1'b0;
    #1;
    we_s = we_cnt;
    check_eq("stall ram_we low", ram_we, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      check_eq($sformatf("stall ram_we cyc%0d", k), ram_we, 0);
    end
    check_eq("stall no writes while low", we_cnt - we_s, 0);
    check_eq("stall busy held", busy, 1);
    enable = 1'b1;
    wait_done("stall", n);
    check_eq("stall resume cycles", n, 4);
    check_eq("stall writes", we_cnt - we0, 2);
    post_checks("stall", 0);
    check_region("stall", 10, 10, 2, 1);

    for (int i = 0; i < 24; i++) begin
      int x = $urandom_range(0, 255), y = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) x = 250 + $urandom_range(0, 5);
      if ($urandom_range(0, 2) == 0) y = 251 + $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) begin
        x = 100 + $urandom_range(0, 3);
        y = 100 + $urandom_range(0, 3);
      end
      run_block(x, y, $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                $urandom_range(0, 63), 18'($urandom), ($urandom_range(0, 3) == 0),
                -1, -1, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a block
    start_block(120, 120, 4, 4, 0, 1, 18'h3, 1, "rstmid");
    repeat (3) @(posedge CLK);
    #1;
    reset = 1'b1;
    @(posedge CLK);
    #1;
    check_eq("rstmid busy", busy, 0);
    check_eq("rstmid ram_we", ram_we, 0);
    check_eq("rstmid blk_done", blk_done, 0);
    check_eq("rstmid blk_ready", blk_ready, 0);
    check_eq("rstmid field_done", field_done, 0);
    check_eq("rstmid wr_count", wr_count, 0);
    check_eq("rstmid ram_addr", ram_addr, 0);
    check_eq("rstmid ram_mv_out", ram_mv_out, 0);
    reset = 1'b0;
    we_s = we_cnt;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK);
      #1;
      if (blk_done) n++;
    end
    check_eq("rstmid no done pulse", n, 0);
    check_eq("rstmid no writes", we_cnt - we_s, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
